capture_controller: RTL and testbench
=====================================

# capture_controller

Sequences the RF capture path: gates ADC samples into the sample FIFO, flushes and primes it before streaming, and enables the FX3 streaming state machine only when data is available. Sits between the ADC capture front end, the dual-clock sample FIFO and the FX3 write state machine, all in the `fx3_clock` domain. Detects FIFO overflow, halts the capture, and reports the overflow to the host via a sticky flag and a saturating count.

## Interface
- `FLUSH_CYCLES`, 8: cycles `fifoClear` is held high on capture start; range 1–255.
- `DATA_WIDTH`, 10: ADC sample width.
- `fx3_clock` in 1: sole clock; all logic on rising edge.
- `fx3_nReset` in 1: reset, synchronous, active-low.
- `collectData` in 1: host capture request from an FX3 GPIO, asynchronous; synchronised internally.
- `adcValid` in 1: `adcData` valid this cycle.
- `adcData` in `DATA_WIDTH`: ADC sample.
- `fifoFull` in 1: sample FIFO full (write side).
- `fifoHalfFull` in 1: sample FIFO at or above half.
- `fifoEmpty` in 1: sample FIFO empty (read side, synchronised by the FIFO).
- `fifoWrite` out 1: FIFO write strobe.
- `fifoData` out `DATA_WIDTH`: FIFO write data.
- `fifoClear` out 1: FIFO synchronous clear.
- `streamEnable` out 1: permits the FX3 write state machine to leave its wait state.
- `overflowFlag` out 1: sticky overflow indicator.
- `overflowCount` out 16: saturating count of overflow events since reset.
- `busy` out 1: high in every state except IDLE.

## Operation
- `collectData` passes through two flops; `collectReq` is the second-stage output.
- States: IDLE, FLUSH, PRIME, RUN, DRAIN, OVERFLOW.
- **IDLE:** all strobes low. Moves to FLUSH when `collectReq`=1.
- **FLUSH:**
  - `fifoClear`=1, `fifoWrite`=0.
  - 8-bit counter runs from 0; at `FLUSH_CYCLES`-1 moves to PRIME.
  - `collectReq` is ignored in this state.
- **PRIME:**
  - `fifoWrite`=`adcValid`, `streamEnable`=0.
  - `fifoHalfFull`=1 moves to RUN.
  - `collectReq`=0 moves to DRAIN.
- **RUN:**
  - `fifoWrite`=`adcValid`, `streamEnable`=1.
  - `adcValid`&`fifoFull` (write attempted while full) moves to OVERFLOW; that sample is not written.
  - Otherwise `collectReq`=0 moves to DRAIN.
  - Overflow wins over stop in the same cycle.
- **DRAIN:**
  - `fifoWrite`=0, `streamEnable`=1.
  - `fifoEmpty`=1 moves to IDLE.
  - A new `collectReq` is ignored until IDLE is reached.
- **OVERFLOW:**
  - `fifoWrite`=0, `streamEnable`=0.
  - `overflowFlag` is set on entry; `overflowCount` increments on entry and saturates at 0xFFFF.
  - `collectReq`=0 moves to IDLE.
- `overflowFlag` clears only on the transition FLUSH→PRIME of the next capture, or on reset.
- `fifoWrite` is never asserted while `fifoFull`=1 (gated in every state).

## Timing
- All outputs are registered, so each output reflects the state/inputs of the previous cycle.
- Reset values:
  - `fifoWrite`=0, `fifoData`=0, `fifoClear`=0, `streamEnable`=0.
  - `overflowFlag`=0, `overflowCount`=0, `busy`=0.
  - State IDLE, synchroniser flops 0.
- Latency:
  - `collectData` rise to FLUSH entry: 3 cycles.
  - `fifoClear` high on the 4th cycle; it lasts exactly `FLUSH_CYCLES` cycles.
- `adcValid`/`adcData` to `fifoWrite`/`fifoData`: 1 cycle.
- `fifoData` updates only when `adcValid`=1; otherwise it holds.
- `streamEnable` deasserts one cycle after OVERFLOW entry or DRAIN exit.
- Reset asserted mid-operation: next edge returns to IDLE with all reset values; FIFO contents are not cleared by this block.

## Configuration
- `CAPTURE_TESTMODE_EN` defined:
  - Adds input `testMode` (1 bit).
  - When `testMode`=1, `fifoData` is a `DATA_WIDTH`-bit counter. It increments per written sample and wraps 0x3FF→0.
  - The counter resets to 0 on FLUSH.
  - `adcData` is ignored in this mode.
- Not defined: no `testMode` port; `fifoData` is always `adcData`.

## Structure
- Package `capture_pkg`:
  - State encoding constants: 3-bit, IDLE=0, FLUSH=1, PRIME=2, RUN=3, DRAIN=4, OVERFLOW=5.
  - Overflow counter width (16) and its saturation value.
- Sub-module `sync2`: two-flop synchroniser for `collectData`, with synchronous active-low reset to 0.

## Test plan
- **Reset and start:** reset, then `collectData`=1 → `fifoClear` high for exactly 8 cycles starting the 4th cycle after the request; then PRIME.
- **Prime and run:** in PRIME, `adcValid`=1 continuously and `fifoHalfFull` asserted at cycle 20 → `streamEnable`=1 one cycle after the RUN transition; `fifoData` tracks `adcData` with 1-cycle latency.
- **Overflow:** in RUN, `fifoFull`=1 with `adcValid`=1 → `fifoWrite` stays 0, `overflowFlag`=1, `overflowCount`=1, `streamEnable`=0. After `collectData`=0 → IDLE; a restart clears `overflowFlag` at PRIME.
- **Simultaneous overflow and stop:** same-cycle `fifoFull`&`adcValid` and `collectReq` fall → OVERFLOW, not DRAIN.
- **Drain:** stop in RUN with `fifoEmpty`=0 for 50 cycles → `streamEnable` stays 1 until `fifoEmpty`=1, then IDLE and `busy`=0.
- **Saturation and test mode:** force 65 536 overflow events → `overflowCount`=0xFFFF. With `CAPTURE_TESTMODE_EN` defined and `testMode`=1, 1025 writes → `fifoData` sequence 0…0x3FF, 0.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding, counter widths and helpers for the
// RF capture controller.
package capture_pkg;

    // Capture sequencer state encoding (3-bit)
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_PRIME    = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_OVERFLOW = 3'd5
    } state_e;

    // Flush cycle counter width; FLUSH_CYCLES must fit (1..255)
    localparam int FLUSH_CNT_W = 8;

    // Overflow event counter width and its saturation value
    localparam int                   OVF_CNT_W   = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 16'hFFFF;

    // Saturating increment for the overflow event counter
    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == OVF_CNT_MAX) ? v : v + OVF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an asynchronous level input, with a
// synchronous active-low reset clearing both stages to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift the asynchronous input through the two stages
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchroniser flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/capture_controller.sv
// capture_controller: sequences the RF capture path (flush, prime, stream,
// drain) between the ADC front end, the sample FIFO and the FX3 write
// state machine, and detects/reports FIFO overflow.
// Optional feature: define CAPTURE_TESTMODE_EN to add the testMode input,
// which replaces ADC data with an incrementing counter pattern.
module capture_controller
    import capture_pkg::*;
#(
    parameter int FLUSH_CYCLES = 8,
    parameter int DATA_WIDTH   = 10
) (
    input  logic                  fx3_clock,
    input  logic                  fx3_nReset,
    input  logic                  collectData,
    input  logic                  adcValid,
    input  logic [DATA_WIDTH-1:0] adcData,
    input  logic                  fifoFull,
    input  logic                  fifoHalfFull,
    input  logic                  fifoEmpty,
`ifdef CAPTURE_TESTMODE_EN
    input  logic                  testMode,
`endif
    output logic                  fifoWrite,
    output logic [DATA_WIDTH-1:0] fifoData,
    output logic                  fifoClear,
    output logic                  streamEnable,
    output logic                  overflowFlag,
    output logic [OVF_CNT_W-1:0]  overflowCount,
    output logic                  busy
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    // Synchronised host capture request
    logic collect_req;

    sync2 u_collect_sync (
        .clk   (fx3_clock),
        .rst_n (fx3_nReset),
        .d     (collectData),
        .q     (collect_req)
    );

    // Sequencer state and flush timer
    state_e                 state_q;
    state_e                 state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_d;

    // Registered outputs
    logic                  fifo_write_q,      fifo_write_d;
    logic [DATA_WIDTH-1:0] fifo_data_q,       fifo_data_d;
    logic                  fifo_clear_q,      fifo_clear_d;
    logic                  stream_enable_q,   stream_enable_d;
    logic                  overflow_flag_q,   overflow_flag_d;
    logic [OVF_CNT_W-1:0]  overflow_count_q,  overflow_count_d;
    logic                  busy_q,            busy_d;
`ifdef CAPTURE_TESTMODE_EN
    logic [DATA_WIDTH-1:0] tm_cnt_q,          tm_cnt_d;
`endif

    // Decoded conditions shared by next-state and output logic
    logic flush_done;
    logic write_attempt_full;
    logic write_ok;
    logic overflow_entry;

    assign flush_done         = (flush_cnt_q == FLUSH_LAST);
    assign write_attempt_full = adcValid & fifoFull;
    // Samples are only written while priming or running, and never into a full FIFO
    assign write_ok           = ((state_q == ST_PRIME) || (state_q == ST_RUN))
                                && adcValid && !fifoFull;
    // Overflow has priority over a stop request in RUN
    assign overflow_entry     = (state_q == ST_RUN) && write_attempt_full;

    // State register and flush timer
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic for the capture sequencer
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (collect_req) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Request level is deliberately ignored until the flush completes
                if (flush_done) begin
                    state_d = ST_PRIME;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
                end
            end
            ST_PRIME: begin
                if (fifoHalfFull) begin
                    state_d = ST_RUN;
                end else if (!collect_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (write_attempt_full) begin
                    state_d = ST_OVERFLOW;
                end else if (!collect_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A fresh request waits until the FIFO has emptied and IDLE is reached
                if (fifoEmpty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVERFLOW: begin
                if (!collect_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: next values for the registered outputs
    always_comb begin
        fifo_write_d     = write_ok;
        fifo_clear_d     = (state_q == ST_FLUSH);
        stream_enable_d  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        busy_d           = (state_q != ST_IDLE);

        // Sticky flag: set on overflow entry, cleared as the next capture leaves FLUSH
        overflow_flag_d  = overflow_flag_q;
        if (overflow_entry) begin
            overflow_flag_d = 1'b1;
        end else if ((state_q == ST_FLUSH) && flush_done) begin
            overflow_flag_d = 1'b0;
        end

        overflow_count_d = overflow_entry ? sat_inc(overflow_count_q) : overflow_count_q;

`ifdef CAPTURE_TESTMODE_EN
        // Test pattern counter restarts on every flush and advances per written sample
        tm_cnt_d = tm_cnt_q;
        if (state_q == ST_FLUSH) begin
            tm_cnt_d = '0;
        end else if (testMode && write_ok) begin
            tm_cnt_d = tm_cnt_q + DATA_WIDTH'(1);
        end

        if (testMode) begin
            fifo_data_d = write_ok ? tm_cnt_q : fifo_data_q;
        end else begin
            fifo_data_d = adcValid ? adcData : fifo_data_q;
        end
`else
        // Data register only loads on a valid ADC sample, otherwise holds
        fifo_data_d = adcValid ? adcData : fifo_data_q;
`endif
    end

    // Output registers
    always_ff @(posedge fx3_clock) begin
        if (!fx3_nReset) begin
            fifo_write_q     <= 1'b0;
            fifo_data_q      <= '0;
            fifo_clear_q     <= 1'b0;
            stream_enable_q  <= 1'b0;
            overflow_flag_q  <= 1'b0;
            overflow_count_q <= '0;
            busy_q           <= 1'b0;
`ifdef CAPTURE_TESTMODE_EN
            tm_cnt_q         <= '0;
`endif
        end else begin
            fifo_write_q     <= fifo_write_d;
            fifo_data_q      <= fifo_data_d;
            fifo_clear_q     <= fifo_clear_d;
            stream_enable_q  <= stream_enable_d;
            overflow_flag_q  <= overflow_flag_d;
            overflow_count_q <= overflow_count_d;
            busy_q           <= busy_d;
`ifdef CAPTURE_TESTMODE_EN
            tm_cnt_q         <= tm_cnt_d;
`endif
        end
    end

    assign fifoWrite     = fifo_write_q;
    assign fifoData      = fifo_data_q;
    assign fifoClear     = fifo_clear_q;
    assign streamEnable  = stream_enable_q;
    assign overflowFlag  = overflow_flag_q;
    assign overflowCount = overflow_count_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed testbench for capture_controller: reset, flush timing, priming,
// run/overflow, simultaneous overflow and stop, drain, counter saturation,
// mid-operation reset and (with CAPTURE_TESTMODE_EN) the test pattern.
module tb_capture_controller;

    logic        clk;
    logic        fx3_nReset;
    logic        collectData;
    logic        adcValid;
    logic [9:0]  adcData;
    logic        fifoFull;
    logic        fifoHalfFull;
    logic        fifoEmpty;
`ifdef CAPTURE_TESTMODE_EN
    logic        testMode;
`endif
    logic        fifoWrite;
    logic [9:0]  fifoData;
    logic        fifoClear;
    logic        streamEnable;
    logic        overflowFlag;
    logic [15:0] overflowCount;
    logic        busy;

    int          vec_count;
    int          miscompares;
    logic [9:0]  exp_data;

    capture_controller #(
        .FLUSH_CYCLES (8),
        .DATA_WIDTH   (10)
    ) dut (
        .fx3_clock     (clk),
        .fx3_nReset    (fx3_nReset),
        .collectData   (collectData),
        .adcValid      (adcValid),
        .adcData       (adcData),
        .fifoFull      (fifoFull),
        .fifoHalfFull  (fifoHalfFull),
        .fifoEmpty     (fifoEmpty),
`ifdef CAPTURE_TESTMODE_EN
        .testMode      (testMode),
`endif
        .fifoWrite     (fifoWrite),
        .fifoData      (fifoData),
        .fifoClear     (fifoClear),
        .streamEnable  (streamEnable),
        .overflowFlag  (overflowFlag),
        .overflowCount (overflowCount),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
        $display("vec %0d %s obs=%b exp=%b", vec_count, tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=0x%0h exp=0x%0h", vec_count, tag, obs, exp);
    endtask

    // One complete capture that ends in overflow and returns to IDLE
    task automatic overflow_event();
        collectData = 1'b1;
        repeat (12) step();            // FLUSH at edge 3, PRIME at 11, RUN at 12
        fifoFull = 1'b1;
        adcValid = 1'b1;
        step();                        // RUN -> OVERFLOW
        fifoFull    = 1'b0;
        adcValid    = 1'b0;
        collectData = 1'b0;
        repeat (3) step();             // request falls through sync, back to IDLE
    endtask

    // Bound the whole run
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_count    = 0;
        miscompares  = 0;
        exp_data     = '0;
        fx3_nReset   = 1'b0;
        collectData  = 1'b0;
        adcValid     = 1'b0;
        adcData      = '0;
        fifoFull     = 1'b0;
        fifoHalfFull = 1'b0;
        fifoEmpty    = 1'b1;
`ifdef CAPTURE_TESTMODE_EN
        testMode     = 1'b0;
`endif

        // Reset values
        step();
        step();
        chk1 ("reset_fifoWrite",     fifoWrite,     1'b0);
        chk16("reset_fifoData",      16'(fifoData), 16'h0000);
        chk1 ("reset_fifoClear",     fifoClear,     1'b0);
        chk1 ("reset_streamEnable",  streamEnable,  1'b0);
        chk1 ("reset_overflowFlag",  overflowFlag,  1'b0);
        chk16("reset_overflowCount", overflowCount, 16'h0000);
        chk1 ("reset_busy",          busy,          1'b0);
        fx3_nReset = 1'b1;
        step();

        // Start: fifoClear high on the 4th cycle for exactly 8 cycles
        collectData = 1'b1;
        repeat (3) step();
        chk1("clear_before_4th", fifoClear, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk1("clear_window", fifoClear, 1'b1);
        end
        step();
        chk1("clear_after_window", fifoClear, 1'b0);
        chk1("busy_in_prime",      busy,      1'b1);

        // Prime: continuous valid samples, half-full on cycle 20
        adcValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 19) fifoHalfFull = 1'b1;
            adcData  = 10'(i * 37 + 5);
            exp_data = adcData;
            step();
            chk1 ("prime_fifoWrite",    fifoWrite,     1'b1);
            chk16("prime_fifoData",     16'(fifoData), 16'(exp_data));
            chk1 ("prime_streamEnable", streamEnable,  1'b0);
        end
        adcData  = 10'h3AA;
        exp_data = adcData;
        step();
        chk1 ("run_streamEnable", streamEnable,  1'b1);
        chk16("run_fifoData",     16'(fifoData), 16'(exp_data));
        chk1 ("run_fifoWrite",    fifoWrite,     1'b1);

        // Overflow: write attempted while full
        fifoFull = 1'b1;
        adcData  = 10'h155;
        step();
        chk1 ("ovf_fifoWrite_gated", fifoWrite,     1'b0);
        chk1 ("ovf_flag",            overflowFlag,  1'b1);
        chk16("ovf_count",           overflowCount, 16'h0001);
        step();
        chk1 ("ovf_streamEnable",    streamEnable,  1'b0);
        chk1 ("ovf_fifoWrite_held",  fifoWrite,     1'b0);
        fifoFull    = 1'b0;
        adcValid    = 1'b0;
        collectData = 1'b0;
        repeat (4) step();
        chk1("ovf_idle_busy",   busy,         1'b0);
        chk1("ovf_flag_sticky", overflowFlag, 1'b1);

        // Restart clears the flag exactly at the FLUSH->PRIME transition
        collectData = 1'b1;
        repeat (10) step();
        chk1("restart_flag_in_flush", overflowFlag, 1'b1);
        step();
        chk1 ("restart_flag_cleared", overflowFlag,  1'b0);
        chk16("restart_count_kept",   overflowCount, 16'h0001);
        step();                        // RUN (half-full still high)

        // Simultaneous overflow and stop: overflow must win
        collectData = 1'b0;
        step();
        step();                        // collectReq now low
        fifoFull = 1'b1;
        adcValid = 1'b1;
        step();
        chk16("simul_count",     overflowCount, 16'h0002);
        chk1 ("simul_fifoWrite", fifoWrite,     1'b0);
        step();
        chk1("simul_streamEnable_low", streamEnable, 1'b0);
        fifoFull = 1'b0;
        adcValid = 1'b0;
        step();
        chk1("simul_idle_busy", busy, 1'b0);

        // Drain: streamEnable held while the FIFO still has data
        fifoEmpty   = 1'b0;
        collectData = 1'b1;
        repeat (12) step();            // RUN
        collectData = 1'b0;
        repeat (3) step();             // DRAIN
        for (int i = 0; i < 50; i++) begin
            step();
            chk1("drain_streamEnable", streamEnable, 1'b1);
        end
        fifoEmpty = 1'b1;
        step();
        chk1("drain_exit_streamEnable", streamEnable, 1'b1);
        step();
        chk1("drain_done_streamEnable", streamEnable, 1'b0);
        chk1("drain_done_busy",         busy,         1'b0);

        // Saturation: preload the counter near the top, then overflow three times
        force dut.overflow_count_q = 16'hFFFD;
        step();
        release dut.overflow_count_q;
        step();
        chk16("sat_preload", overflowCount, 16'hFFFD);
        overflow_event();
        chk16("sat_count_fffe", overflowCount, 16'hFFFE);
        overflow_event();
        chk16("sat_count_ffff", overflowCount, 16'hFFFF);
        overflow_event();
        chk16("sat_count_hold", overflowCount, 16'hFFFF);

        // Reset mid-flush returns everything to reset values
        collectData = 1'b1;
        repeat (5) step();
        chk1("midrst_clear_before", fifoClear, 1'b1);
        fx3_nReset  = 1'b0;
        collectData = 1'b0;
        step();
        chk1 ("midrst_fifoClear",     fifoClear,     1'b0);
        chk1 ("midrst_busy",          busy,          1'b0);
        chk1 ("midrst_overflowFlag",  overflowFlag,  1'b0);
        chk16("midrst_overflowCount", overflowCount, 16'h0000);
        fx3_nReset = 1'b1;
        step();

`ifdef CAPTURE_TESTMODE_EN
        // Test pattern: 1025 written samples give 0..0x3FF then wrap to 0
        testMode    = 1'b1;
        adcValid    = 1'b1;
        adcData     = 10'h2AB;
        collectData = 1'b1;
        repeat (11) step();            // PRIME entered
        for (int k = 0; k < 1025; k++) begin
            step();
            chk16("tm_fifoData", 16'(fifoData), 16'(k % 1024));
        end
        chk1("tm_fifoWrite", fifoWrite, 1'b1);
        adcValid    = 1'b0;
        collectData = 1'b0;
        testMode    = 1'b0;
        repeat (4) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
